decoder2x4_act: RTL and testbench
=================================

# decoder2x4_act

Registered 2-to-4 one-hot decoder with a valid/ready pipeline stage and built-in per-output toggle-activity counters. It is the decode-side counterpart of the 4-to-2 encoder in the power-estimation datapath. Bench and accelerator logic read switching-activity figures straight from the block over a fixed measurement window, without post-processing a VCD.

## Interface
- `CNT_W`, 16: width of each per-bit toggle counter. Minimum 2.
- `WINDOW`, 64: measurement window length in clock edges. Minimum 1; 0 is illegal.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `d`  in  2  code to decode.
- `en`  in  1  decode enable, sampled with the beat.
- `out`  out  4  registered one-hot result.
- `out_valid`  out  1  `out` holds an unconsumed beat.
- `out_ready`  in  1  downstream accepts the beat.
- `start`  in  1  one-cycle pulse that begins a measurement window.
- `busy`  out  1  window in progress.
- `done`  out  1  window finished; counters are frozen.
- `tog_cnt`  out  4*CNT_W  packed per-bit toggle counts; bit i occupies `[i*CNT_W +: CNT_W]`.
- `tog_total`  out  CNT_W+2  sum of toggles on all four bits.

## Operation
- Accept: a beat transfers when `in_valid & in_ready`.
  - `in_ready = ~out_valid | out_ready`, which is combinational and gives a single-entry pipeline.
- Decode on accept: `out <= en ? (4'b0001 << d) : 4'b0000`, and `out_valid <= 1`.
- Consume without a new beat: if `out_valid & out_ready` with no accept, then `out_valid <= 0` and `out` holds its value.
  - `out` changes only on accepted beats. Idle cycles cause no switching.
- Back-pressure: while `out_valid & ~out_ready`, `out` and `out_valid` hold and `in_ready` is 0.
- Activity detection: `chg[3:0] = next_out ^ out`, evaluated at every edge.
- FSM states are IDLE, RUN and DONE.
  - IDLE: `busy` = 0, `done` = 0. `start` leads to RUN.
  - RUN: `busy` = 1. The window counter is loaded with WINDOW-1 on entry and decrements each edge. At the edge where it reads 0, go to DONE. RUN therefore lasts exactly WINDOW edges.
  - DONE: `done` = 1 and counters hold. `start` leads to RUN.
  - `start` while in RUN is ignored.
- Counting happens only on edges taken while in RUN.
  - Each `tog_cnt[i]` increments by `chg[i]`.
  - `tog_total` increments by popcount(`chg`), i.e. 0 to 4.
- Clear: on the edge that moves IDLE or DONE into RUN, all counters clear to 0. Clear wins over any `chg` on that same edge, which is not counted.
- Saturation: each `tog_cnt[i]` saturates at all-ones and never wraps. `tog_total` saturates independently at all-ones of CNT_W+2 bits.
  - `tog_total` therefore equals the sum of the per-bit counts unless some count has saturated.
- Decoding is independent of the FSM. Beats flow in every state.

## Timing
- Reset values: `out` = 0000, `out_valid` = 0, `busy` = 0, `done` = 0, `tog_cnt` = 0, `tog_total` = 0, state IDLE, window counter 0.
- `in_ready` = 1 out of reset.
- Decode latency: 1 cycle from the accepting edge to `out`/`out_valid`.
- `busy` rises 1 edge after `start` is sampled.
- `done` rises and `busy` falls together, WINDOW edges after `busy` rose.
- Counter updates are visible 1 cycle after the counted edge. They are final when `done` = 1.
- Asserting `rst` mid-window aborts it immediately (asynchronous): all outputs return to reset values and no partial counts are retained.
- A `start` in the same cycle as the last RUN edge is ignored. The block still enters DONE.

## Test plan
- Reset check: assert `rst` mid-stream → all outputs at reset values and `in_ready` = 1; deassert → first beat d=2, en=1 gives `out` = 0100 one cycle later.
- Decode sweep: `out_ready` = 1, d = 0, 1, 2, 3 with en=1 → `out` = 0001, 0010, 0100, 1000. Then d=3, en=0 → `out` = 0000.
- Back-pressure: `out_ready` = 0 with a beat held → `in_ready` = 0 and `out` stable for 5 cycles. Release → held beat consumed; next beat accepted the following edge.
- Window count: WINDOW=8, `start`, then beats d=0, 1, 2, 3 (en=1) on RUN edges 1–4 starting from `out` = 0000 → `done` after 8 edges with `tog_cnt` = {1, 2, 2, 2} (bit3..bit0) and `tog_total` = 7. Beats after `done` leave the counts unchanged.
- Saturation: CNT_W=2, WINDOW=16, alternate d=0 and d=1 every edge → `tog_cnt[0]` and `tog_cnt[1]` stop at 3 and `tog_total` stops at 15.
- Restart / abort: `start` in DONE → counters read 0 on the next cycle and `busy` = 1. Assert `rst` at RUN edge 3 → `busy` = 0 and all counts 0.

Source files
------------

// File: rtl/decoder2x4_act.sv
// Registered 2-to-4 one-hot decoder behind a single-entry valid/ready
// stage, with windowed per-output toggle counters for activity figures.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input handshake; d (code) and en sampled on accept
//   out/out_valid     registered one-hot result; out_ready consumes it
//   start             pulse that opens a WINDOW-edge measurement window
//   busy/done         window in progress / window finished (counts frozen)
//   tog_cnt           per-bit toggle counts, bit i at [i*CNT_W +: CNT_W]
//   tog_total         saturating sum of toggles over all four bits
module decoder2x4_act #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         d,
  input  logic               en,
  output logic [3:0]         out,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [4*CNT_W-1:0] tog_cnt,
  output logic [CNT_W+1:0]   tog_total
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W+1:0] TOT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIN_W-1:0]   win;
  logic [CNT_W-1:0]   cnt [4];

  logic               accept;
  logic [3:0]         next_out;
  logic [3:0]         chg;
  logic [2:0]         pop;
  logic [CNT_W+2:0]   tot_sum;
  logic [CNT_W+1:0]   tot_next;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    next_out = out;
    if (accept) begin
      next_out = en ? (4'b0001 << d) : 4'b0000;
    end
  end

  assign chg = next_out ^ out;
  assign pop = 3'(chg[0]) + 3'(chg[1])
             + 3'(chg[2]) + 3'(chg[3]);

  // One spare bit catches the carry so saturation is exact.
  assign tot_sum  = {1'b0, tog_total} + (CNT_W + 3)'(pop);
  assign tot_next = tot_sum[CNT_W+2] ? TOT_MAX
                                     : tot_sum[CNT_W+1:0];

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign tog_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= 4'b0000;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= next_out;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      win       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tog_total <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      case (state)
        RUN: begin
          for (int i = 0; i < 4; i++) begin
            if (chg[i] && cnt[i] != CNT_MAX) begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          tog_total <= tot_next;
          if (win == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            win <= win - WIN_W'(1);
          end
        end
        IDLE, DONE: begin
          // Clearing on entry drops this edge's toggles.
          if (start) begin
            state     <= RUN;
            win       <= WIN_LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            tog_total <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder2x4_act.sv
// Bench for decoder2x4_act: two instances (wide/narrow counters)
// share stimulus; directed tables plus random beats against a model.
module tb_decoder2x4_act;

  localparam int CW_A = 16;
  localparam int W_A  = 8;
  localparam int CW_B = 2;
  localparam int W_B  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic start = 1'b0;
  logic en = 1'b0;
  logic [1:0] d = 2'd0;

  logic in_ready_a, out_valid_a, busy_a, done_a;
  logic in_ready_b, out_valid_b, busy_b, done_b;
  logic [3:0] out_a, out_b;
  logic [4*CW_A-1:0] cnt_a;
  logic [4*CW_B-1:0] cnt_b;
  logic [CW_A+1:0] tot_a;
  logic [CW_B+1:0] tot_b;

  always #5 clk = ~clk;

  decoder2x4_act #(.CNT_W(CW_A), .WINDOW(W_A)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .d(d), .en(en),
    .out(out_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .start(start),
    .busy(busy_a), .done(done_a),
    .tog_cnt(cnt_a), .tog_total(tot_a)
  );

  decoder2x4_act #(.CNT_W(CW_B), .WINDOW(W_B)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .d(d), .en(en),
    .out(out_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .start(start),
    .busy(busy_b), .done(done_b),
    .tog_cnt(cnt_b), .tog_total(tot_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference: phase 0 idle, 1 measuring, 2 finished.
  int m_out, m_ov;
  int m_ph [2];
  int m_left [2];
  int m_cnt [2][4];
  int m_tot [2];
  int cw [2];
  int wn [2];

  typedef struct {
    logic [1:0] d;
    logic       en;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0;
    m_ov  = 0;
    for (int k = 0; k < 2; k++) begin
      m_ph[k]   = 0;
      m_left[k] = 0;
      m_tot[k]  = 0;
      for (int b = 0; b < 4; b++) m_cnt[k][b] = 0;
    end
  endtask

  task automatic model_step();
    int ready, acc, nout, nv, n, lim;
    int flips [4];
    ready = (m_ov == 0) || out_ready;
    acc   = in_valid && ready;
    nout  = acc ? (en ? (1 << d) : 0) : m_out;
    nv    = acc ? 1 : ((m_ov != 0 && out_ready) ? 0 : m_ov);
    for (int b = 0; b < 4; b++)
      flips[b] = (((nout >> b) & 1) != ((m_out >> b) & 1)) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (m_ph[k] == 1) begin
        n   = 0;
        lim = (1 << cw[k]) - 1;
        for (int b = 0; b < 4; b++) begin
          m_cnt[k][b] += flips[b];
          if (m_cnt[k][b] > lim) m_cnt[k][b] = lim;
          n += flips[b];
        end
        lim = (1 << (cw[k] + 2)) - 1;
        m_tot[k] += n;
        if (m_tot[k] > lim) m_tot[k] = lim;
        m_left[k]--;
        if (m_left[k] == 0) m_ph[k] = 2;
      end else if (start) begin
        m_ph[k]   = 1;
        m_left[k] = wn[k];
        m_tot[k]  = 0;
        for (int b = 0; b < 4; b++) m_cnt[k][b] = 0;
      end
    end
    m_out = nout;
    m_ov  = nv;
  endtask

  task automatic compare();
    int rdy;
    rdy = ((m_ov == 0) || out_ready) ? 1 : 0;
    chk("a.out", out_a, m_out);
    chk("b.out", out_b, m_out);
    chk("a.out_valid", out_valid_a, m_ov);
    chk("b.out_valid", out_valid_b, m_ov);
    chk("a.in_ready", in_ready_a, rdy);
    chk("b.in_ready", in_ready_b, rdy);
    chk("a.busy", busy_a, m_ph[0] == 1);
    chk("b.busy", busy_b, m_ph[1] == 1);
    chk("a.done", done_a, m_ph[0] == 2);
    chk("b.done", done_b, m_ph[1] == 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a.cnt%0d", i),
          cnt_a[i*CW_A +: CW_A], m_cnt[0][i]);
      chk($sformatf("b.cnt%0d", i),
          cnt_b[i*CW_B +: CW_B], m_cnt[1][i]);
    end
    chk("a.total", tot_a, m_tot[0]);
    chk("b.total", tot_b, m_tot[1]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    cw[0] = CW_A; cw[1] = CW_B;
    wn[0] = W_A;  wn[1] = W_B;
    tbl[0] = '{2'd0, 1'b1, 4'b0001};
    tbl[1] = '{2'd1, 1'b1, 4'b0010};
    tbl[2] = '{2'd2, 1'b1, 4'b0100};
    tbl[3] = '{2'd3, 1'b1, 4'b1000};
    tbl[4] = '{2'd3, 1'b0, 4'b0000};

    // Reset values
    #2;
    model_reset();
    compare();
    chk("rst.in_ready", in_ready_a, 1);
    chk("rst.out", out_a, 0);
    chk("rst.busy", busy_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First beat after reset
    out_ready = 1'b1;
    in_valid = 1'b1; d = 2'd2; en = 1'b1;
    tick();
    chk("first.out", out_a, 4'b0100);
    chk("first.valid", out_valid_a, 1);

    // Decode sweep
    for (int i = 0; i < 5; i++) begin
      d  = tbl[i].d;
      en = tbl[i].en;
      tick();
      chk($sformatf("sweep%0d.a", i), out_a, tbl[i].exp);
      chk($sformatf("sweep%0d.b", i), out_b, tbl[i].exp);
    end

    // Back-pressure
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; d = 2'd1; en = 1'b1; out_ready = 1'b0;
    tick();
    chk("bp.load", out_a, 4'b0010);
    d = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.in_ready", in_ready_a, 0);
      chk("bp.hold", out_a, 4'b0010);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release", in_ready_a, 1);
    tick();
    chk("bp.next", out_a, 4'b1000);

    // Window count on instance a
    en = 1'b0;
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("win.busy", busy_a, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; en = 1'b1; d = 2'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("win.early", done_a, 0);
    tick();
    chk("win.done", done_a, 1);
    chk("win.busy_off", busy_a, 0);
    chk("win.cnt3", cnt_a[3*CW_A +: CW_A], 1);
    chk("win.cnt2", cnt_a[2*CW_A +: CW_A], 2);
    chk("win.cnt1", cnt_a[1*CW_A +: CW_A], 2);
    chk("win.cnt0", cnt_a[0*CW_A +: CW_A], 2);
    chk("win.total", tot_a, 7);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; d = 2'($urandom_range(0, 3));
      tick();
    end
    chk("win.frozen", tot_a, 7);
    chk("win.frozen0", cnt_a[0 +: CW_A], 2);

    // Let instance b finish, bounded
    in_valid = 1'b0;
    for (int n = 0; n < 40 && !(done_a && done_b); n++)
      tick();
    chk("wait.done_b", done_b, 1);

    // Restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart.busy_a", busy_a, 1);
    chk("restart.busy_b", busy_b, 1);
    chk("restart.tot_a", tot_a, 0);
    chk("restart.cnt_a", cnt_a, 0);
    chk("restart.tot_b", tot_b, 0);

    // Saturation on narrow counters
    for (int n = 0; n < 16; n++) begin
      in_valid = 1'b1; en = 1'b1; d = 2'(n % 2);
      tick();
    end
    chk("sat.done", done_b, 1);
    chk("sat.cnt0", cnt_b[0 +: CW_B], 3);
    chk("sat.cnt1", cnt_b[CW_B +: CW_B], 3);
    chk("sat.total", tot_b, 15);

    // Abort mid-window
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      d = 2'(n + 2);
      tick();
    end
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    chk("abort.busy", busy_a, 0);
    chk("abort.tot", tot_a, 0);
    chk("abort.cnt", cnt_a, 0);
    chk("abort.in_ready", in_ready_a, 1);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      d         = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 15) == 0);
      tick();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        rst = 1'b0;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
